// File: rtl/control_sequencer.sv
// Hardwired control unit for a single-bus CPU: walks T-steps per opcode class and
// raises datapath strobes from the current step; memory steps stall on mem_ready.
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int IR_W     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            PCin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            CONin,
  output logic [OPW-1:0]  alu_op,
  output logic [3:0]      step,
  output logic            halted,
  output logic            bus_err
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd15
  } state_t;

  state_t         state, state_nx;
  logic [7:0]     wait_cnt, wait_nx;
  logic           set_halted, set_bus_err;
  logic           mem_step;
  logic [OPW-1:0] opcode;
  logic           is_ld, is_ldi, is_st, is_ralu, is_ialu, is_br, is_jr, is_nop, is_halt;
  logic           is_legal;
  logic           unused_ir;

  assign opcode    = ir[IR_W-1 -: OPW];
  assign unused_ir = ^ir[IR_W-OPW-1:0];

  assign is_ld    = (opcode == OPW'(0));
  assign is_ldi   = (opcode == OPW'(1));
  assign is_st    = (opcode == OPW'(2));
  assign is_ralu  = (opcode >= OPW'(3))  && (opcode <= OPW'(11));
  assign is_ialu  = (opcode >= OPW'(12)) && (opcode <= OPW'(14));
  assign is_br    = (opcode == OPW'(19));
  assign is_jr    = (opcode == OPW'(20));
  assign is_nop   = (opcode == OPW'(26));
  assign is_halt  = (opcode == OPW'(27));
  assign is_legal = is_ld | is_ldi | is_st | is_ralu | is_ialu | is_br | is_jr | is_nop | is_halt;

  assign step     = state;
  assign mem_step = Read | Write;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= T0;
      wait_cnt <= '0;
      halted   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (set_halted)  halted  <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  // Strobe decode. T0 fetch strobes are qualified by run so an idle T0 drives nothing.
  always_comb begin
    {PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
     Zhighout, PCin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin} = '0;
    alu_op = '0;
    case (state)
      T0: if (run) begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_ld || is_ldi || is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_ralu || is_ialu)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_br)               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (is_jr)               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      end
      T4: begin
        if (is_ld || is_ldi || is_st) begin Cout = 1'b1; Zin = 1'b1; alu_op = OPW'(3); end
        else if (is_ralu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_ialu) begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_br)   begin PCout = 1'b1; Yin = 1'b1; end
      end
      T5: begin
        if (is_ldi || is_ralu || is_ialu) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_ld || is_st)          begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (is_br)                   begin Cout = 1'b1; Zin = 1'b1; alu_op = OPW'(3); end
      end
      T6: begin
        if (is_ld)      begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br) begin Zlowout = 1'b1; PCin = con_ff; end
      end
      T7: begin
        if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx    = state;
    wait_nx     = '0;
    set_halted  = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      T0: if (run) state_nx = T1;
      T1: state_nx = T2;
      T2: begin
        if (!is_legal)    begin state_nx = HALT; set_bus_err = 1'b1; end
        else if (is_halt) begin state_nx = HALT; set_halted  = 1'b1; end
        else if (is_nop)  state_nx = T0;
        else              state_nx = T3;
      end
      T3:      state_nx = is_jr ? T0 : T4;
      T4:      state_nx = T5;
      T5:      state_nx = (is_ld || is_st || is_br) ? T6 : T0;
      T6:      state_nx = is_br ? T0 : T7;
      T7:      state_nx = T0;
      HALT:    state_nx = HALT;
      default: state_nx = HALT;
    endcase
    // A memory step holds until mem_ready; the WAIT_MAX-th unanswered cycle is a bus error.
    if (mem_step && !mem_ready) begin
      if (wait_cnt == 8'(WAIT_MAX - 1)) begin
        state_nx    = HALT;
        set_bus_err = 1'b1;
      end else begin
        state_nx = state;
        wait_nx  = wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle step, strobe, alu_op and flag checks
// against hand-written expectations for each instruction class and the wait/halt paths.
module tb_control_sequencer;
  localparam int OPW      = 5;
  localparam int IR_W     = 32;
  localparam int WAIT_MAX = 4;

  localparam logic [20:0] M_PCOUT   = 21'h100000;
  localparam logic [20:0] M_MARIN   = 21'h080000;
  localparam logic [20:0] M_INCPC   = 21'h040000;
  localparam logic [20:0] M_READ    = 21'h020000;
  localparam logic [20:0] M_WRITE   = 21'h010000;
  localparam logic [20:0] M_MDRIN   = 21'h008000;
  localparam logic [20:0] M_MDROUT  = 21'h004000;
  localparam logic [20:0] M_IRIN    = 21'h002000;
  localparam logic [20:0] M_YIN     = 21'h001000;
  localparam logic [20:0] M_ZIN     = 21'h000800;
  localparam logic [20:0] M_ZLOWOUT = 21'h000400;
  localparam logic [20:0] M_PCIN    = 21'h000100;
  localparam logic [20:0] M_GRA     = 21'h000080;
  localparam logic [20:0] M_GRB     = 21'h000040;
  localparam logic [20:0] M_GRC     = 21'h000020;
  localparam logic [20:0] M_RIN     = 21'h000010;
  localparam logic [20:0] M_ROUT    = 21'h000008;
  localparam logic [20:0] M_BAOUT   = 21'h000004;
  localparam logic [20:0] M_COUT    = 21'h000002;
  localparam logic [20:0] M_CONIN   = 21'h000001;

  logic            clk = 1'b0;
  logic            clr, run, con_ff, mem_ready;
  logic [IR_W-1:0] ir;
  logic PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic Zhighout, PCin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [OPW-1:0]  alu_op;
  logic [3:0]      step;
  logic            halted, bus_err;
  logic [20:0]     strobes;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.OPW(OPW), .IR_W(IR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
    .alu_op(alu_op), .step(step), .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign strobes = {PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin, Yin, Zin,
                    Zlowout, Zhighout, PCin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample one cycle at the falling edge, then step to just after the next rising edge.
  task automatic cyc(input string tag, input int st, input logic [20:0] sb, input int op,
                     input logic [1:0] fl);
    @(negedge clk);
    check({tag, "_step"}, 32'(step), 32'(st));
    check({tag, "_strb"}, 32'(strobes), 32'(sb));
    check({tag, "_alu"}, 32'(alu_op), 32'(op));
    check({tag, "_flag"}, {30'b0, halted, bus_err}, 32'(fl));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; run = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic fetch(input string tag);
    run = 1'b1; mem_ready = 1'b1;
    cyc({tag, "_t0"}, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 2'b00);
    cyc({tag, "_t1"}, 1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 2'b00);
    cyc({tag, "_t2"}, 2, M_MDROUT | M_IRIN, 0, 2'b00);
  endtask

  task automatic back_to_t0(input string tag);
    run = 1'b0;
    cyc({tag, "_end"}, 0, '0, 0, 2'b00);
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;

    // Idle after reset with run low.
    for (int i = 0; i < 5; i++) cyc("idle", 0, '0, 0, 2'b00);

    // add (R-ALU, opcode 3)
    ir = 32'h1800_0000;
    fetch("add");
    cyc("add_t3", 3, M_GRB | M_ROUT | M_YIN, 0, 2'b00);
    cyc("add_t4", 4, M_GRC | M_ROUT | M_ZIN, 3, 2'b00);
    cyc("add_t5", 5, M_ZLOWOUT | M_GRA | M_RIN, 0, 2'b00);
    back_to_t0("add");

    // ld with three unanswered cycles in T6
    ir = 32'h0300_0002;
    fetch("ld");
    cyc("ld_t3", 3, M_GRB | M_BAOUT | M_YIN, 0, 2'b00);
    cyc("ld_t4", 4, M_COUT | M_ZIN, 3, 2'b00);
    cyc("ld_t5", 5, M_ZLOWOUT | M_MARIN, 0, 2'b00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_t6w", 6, M_READ | M_MDRIN, 0, 2'b00);
    mem_ready = 1'b1;
    cyc("ld_t6r", 6, M_READ | M_MDRIN, 0, 2'b00);
    cyc("ld_t7", 7, M_MDROUT | M_GRA | M_RIN, 0, 2'b00);
    back_to_t0("ld");

    // ldi
    ir = 32'h0800_0000;
    fetch("ldi");
    cyc("ldi_t3", 3, M_GRB | M_BAOUT | M_YIN, 0, 2'b00);
    cyc("ldi_t4", 4, M_COUT | M_ZIN, 3, 2'b00);
    cyc("ldi_t5", 5, M_ZLOWOUT | M_GRA | M_RIN, 0, 2'b00);
    back_to_t0("ldi");

    // st with one unanswered Write cycle
    ir = 32'h1000_0000;
    fetch("st");
    cyc("st_t3", 3, M_GRB | M_BAOUT | M_YIN, 0, 2'b00);
    cyc("st_t4", 4, M_COUT | M_ZIN, 3, 2'b00);
    cyc("st_t5", 5, M_ZLOWOUT | M_MARIN, 0, 2'b00);
    cyc("st_t6", 6, M_GRA | M_ROUT | M_MDRIN, 0, 2'b00);
    mem_ready = 1'b0;
    cyc("st_t7w", 7, M_WRITE, 0, 2'b00);
    mem_ready = 1'b1;
    cyc("st_t7r", 7, M_WRITE, 0, 2'b00);
    back_to_t0("st");

    // I-ALU, opcode 12
    ir = 32'h6000_0000;
    fetch("ialu");
    cyc("ialu_t3", 3, M_GRB | M_ROUT | M_YIN, 0, 2'b00);
    cyc("ialu_t4", 4, M_COUT | M_ZIN, 12, 2'b00);
    cyc("ialu_t5", 5, M_ZLOWOUT | M_GRA | M_RIN, 0, 2'b00);
    back_to_t0("ialu");

    // br, condition false then true
    ir = 32'h9B00_0019;
    for (int c = 0; c < 2; c++) begin
      con_ff = (c == 1);
      fetch("br");
      cyc("br_t3", 3, M_GRA | M_ROUT | M_CONIN, 0, 2'b00);
      cyc("br_t4", 4, M_PCOUT | M_YIN, 0, 2'b00);
      cyc("br_t5", 5, M_COUT | M_ZIN, 3, 2'b00);
      cyc("br_t6", 6, (c == 1) ? (M_ZLOWOUT | M_PCIN) : M_ZLOWOUT, 0, 2'b00);
      back_to_t0("br");
    end
    con_ff = 1'b0;

    // jr
    ir = 32'hA000_0000;
    fetch("jr");
    cyc("jr_t3", 3, M_GRA | M_ROUT | M_PCIN, 0, 2'b00);
    back_to_t0("jr");

    // nop
    ir = 32'hD000_0000;
    fetch("nop");
    back_to_t0("nop");

    // halt: HALT ignores run
    ir = 32'hD800_0000;
    fetch("halt");
    cyc("halt_s", 15, '0, 0, 2'b10);
    cyc("halt_hold", 15, '0, 0, 2'b10);

    // clr during a T1 wait
    do_reset();
    ir = 32'hD000_0000;
    run = 1'b1; mem_ready = 1'b0;
    cyc("cw_t0", 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 2'b00);
    cyc("cw_t1", 1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 2'b00);
    cyc("cw_t1", 1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 2'b00);
    clr = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    cyc("cw_clr", 0, '0, 0, 2'b00);

    // mem_ready stuck low in T1: bus error after WAIT_MAX cycles
    run = 1'b1;
    cyc("be_t0", 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 2'b00);
    for (int i = 0; i < WAIT_MAX; i++)
      cyc("be_t1", 1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 2'b00);
    cyc("be_halt", 15, '0, 0, 2'b01);
    cyc("be_hold", 15, '0, 0, 2'b01);

    // illegal opcode 15
    do_reset();
    ir = 32'h7800_0000;
    fetch("ill");
    cyc("ill_halt", 15, '0, 0, 2'b01);

    do_reset();
    cyc("final", 0, '0, 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
